// File: rtl/add4_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit add4 slice per cycle,
// LSB first, with the inter-slice carry held in a register.

// 4-bit ripple slice; purely combinational.
module add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s_c,
   output logic       cout_c
);

   // Five-bit sum so the slice carry-out falls out of the top bit
   assign {cout_c, s_c} = 5'(a) + 5'(b) + 5'(cin);

endmodule

module add4_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int unsigned SHW    = IDXW + 2;
   localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NSLICE - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'(4'hF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_n;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;      // already inverted for subtraction
   logic [WIDTH-1:0] a_n;
   logic [WIDTH-1:0] b_n;
   logic [WIDTH-1:0] sum_n;
   logic             carry;
   logic             carry_n;
   logic             cout_n;
   logic             ovf_n;
   logic [IDXW-1:0]  idx;
   logic [IDXW-1:0]  idx_n;

   logic [SHW-1:0]   lo;
   logic [3:0]       sl_a;
   logic [3:0]       sl_b;
   logic [3:0]       sl_s;
   logic             sl_co;

   // Bit offset of the current slice; shifting avoids out-of-range part selects
   assign lo   = {idx, 2'b00};
   assign sl_a = 4'(a_q >> lo);
   assign sl_b = 4'(b_q >> lo);

   add4 u_add4 (
      .a      (sl_a),
      .b      (sl_b),
      .cin    (carry),
      .s_c    (sl_s),
      .cout_c (sl_co)
   );

   // State register plus registered handshake/status flags derived from next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         in_ready  <= (state_n == IDLE);
         busy      <= (state_n != IDLE);
         out_valid <= (state_n == DONE);
      end
   end

   // Next-state and datapath update: capture in IDLE, one slice per RUN cycle
   always_comb begin
      state_n = state;
      a_n     = a_q;
      b_n     = b_q;
      carry_n = carry;
      idx_n   = idx;
      sum_n   = sum;
      cout_n  = cout;
      ovf_n   = ovf;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_n     = a;
               b_n     = sub ? ~b : b;
               carry_n = sub | cin;
               idx_n   = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            sum_n   = (sum & ~(SLICE_MASK << lo)) | (WIDTH'(sl_s) << lo);
            carry_n = sl_co;
            idx_n   = idx + 1'b1;
            if (idx == LAST_IDX) begin
               cout_n  = sl_co;
               ovf_n   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[3] != a_q[WIDTH-1]);
               idx_n   = '0;
               state_n = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         a_q   <= a_n;
         b_q   <= b_n;
         carry <= carry_n;
         idx   <= idx_n;
         sum   <= sum_n;
         cout  <= cout_n;
         ovf   <= ovf_n;
      end
   end

endmodule

// File: tb/tb_add4_seq_ctrl.sv
// Bench for add4_seq_ctrl: directed cases on a 16-bit instance plus
// randomized handshake regressions at WIDTH = 4, 16 and 32.
module tb_add4_seq_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- directed 16-bit instance ----------------
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   add4_seq_ctrl #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   // Called at a negedge in IDLE; returns at the negedge after the accept edge
   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb);
      chk("issue_rdy", 64'(in_ready), 64'(1));
      a        = av;
      b        = bv;
      cin      = ci;
      sub      = sb;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      cin      = 1'($urandom);
      sub      = 1'($urandom);
   endtask

   // Waits (bounded) for out_valid and checks latency and result
   task automatic wait_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
      int lat = 0;
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(4));
      chk({tag, "_sum"}, 64'(sum), 64'(es));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
   endtask

   // Consumes the result and confirms return to IDLE
   task automatic take(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ovld_lo"}, 64'(out_valid), 64'(0));
      chk({tag, "_idle_rdy"}, 64'(in_ready), 64'(1));
      chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
   endtask

   // ---------------- randomized instances ----------------
   logic rst_rnd;
   bit   rnd_go = 1'b0;

   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int unsigned W  = (g == 0) ? 4 : (g == 1) ? 16 : 32;
      localparam int unsigned NS = W / 4;

      logic         iv;
      logic         ir;
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic         ci;
      logic         sb;
      logic         ov;
      logic         ordy;
      logic [W-1:0] sm;
      logic         co;
      logic         of;
      logic         bz;
      bit           done = 1'b0;

      add4_seq_ctrl #(.WIDTH(W)) dut_r (
         .clk       (clk),
         .rst       (rst_rnd),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (av),
         .b         (bv),
         .cin       (ci),
         .sub       (sb),
         .out_valid (ov),
         .out_ready (ordy),
         .sum       (sm),
         .cout      (co),
         .ovf       (of),
         .busy      (bz)
      );

      // Operand picker biased towards carry/overflow corner values
      function automatic logic [W-1:0] pick();
         logic [W-1:0] v;
         case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'({$urandom, $urandom});
         endcase
         return v;
      endfunction

      // Transaction-level model: one pending op, result visible NS edges after accept
      initial begin
         logic [W-1:0] bx;
         logic [W:0]   full;
         logic [W-1:0] exp_s;
         logic         exp_c;
         logic         exp_o;
         logic         exp_ov;
         bit           pend;
         int           k;
         int           n_acc;
         int           n_dlv;
         iv    = 1'b0;
         ordy  = 1'b0;
         av    = '0;
         bv    = '0;
         ci    = 1'b0;
         sb    = 1'b0;
         pend  = 1'b0;
         k     = 0;
         n_acc = 0;
         n_dlv = 0;
         exp_s = '0;
         exp_c = 1'b0;
         exp_o = 1'b0;
         wait (rnd_go);
         @(negedge clk);
         for (int cyc = 0; cyc < 3000; cyc++) begin
            if (pend) k++;
            exp_ov = pend && (k >= int'(NS));
            chk($sformatf("w%0d_in_ready", W), 64'(ir), 64'(!pend));
            chk($sformatf("w%0d_busy", W), 64'(bz), 64'(pend));
            chk($sformatf("w%0d_out_valid", W), 64'(ov), 64'(exp_ov));
            if (exp_ov) begin
               chk($sformatf("w%0d_sum", W), 64'(sm), 64'(exp_s));
               chk($sformatf("w%0d_cout", W), 64'(co), 64'(exp_c));
               chk($sformatf("w%0d_ovf", W), 64'(of), 64'(exp_o));
            end
            iv   = (cyc < 2950) && ($urandom_range(0, 3) != 0);
            av   = pick();
            bv   = pick();
            ci   = 1'($urandom);
            sb   = 1'($urandom);
            ordy = (cyc >= 2950) || ($urandom_range(0, 2) != 0);
            if (exp_ov && ordy) begin
               pend = 1'b0;
               n_dlv++;
            end else if (!pend && iv) begin
               bx    = sb ? ~bv : bv;
               full  = {1'b0, av} + {1'b0, bx} + (W+1)'(sb | ci);
               exp_s = full[W-1:0];
               exp_c = full[W];
               exp_o = (av[W-1] == bx[W-1]) && (exp_s[W-1] != av[W-1]);
               pend  = 1'b1;
               k     = -1;
               n_acc++;
            end
            @(negedge clk);
         end
         chk($sformatf("w%0d_one_result_per_accept", W), 64'(n_dlv), 64'(n_acc));
         chk($sformatf("w%0d_drained", W), 64'(pend), 64'(0));
         done = 1'b1;
      end
   end

   // ---------------- directed sequence ----------------
   logic [15:0] ta  [6];
   logic [15:0] tbv [6];
   logic        tc  [6];
   logic        ts  [6];
   logic [15:0] es  [6];
   logic        ec  [6];
   logic        eo  [6];

   initial begin
      int t;
      int ov_seen;
      rst       = 1'b1;
      rst_rnd   = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;

      ta[0] = 16'h00FF; tbv[0] = 16'h0001; tc[0] = 0; ts[0] = 0; es[0] = 16'h0100; ec[0] = 0; eo[0] = 0;
      ta[1] = 16'hFFFF; tbv[1] = 16'h0001; tc[1] = 0; ts[1] = 0; es[1] = 16'h0000; ec[1] = 1; eo[1] = 0;
      ta[2] = 16'h7FFF; tbv[2] = 16'h0001; tc[2] = 0; ts[2] = 0; es[2] = 16'h8000; ec[2] = 0; eo[2] = 1;
      ta[3] = 16'h0005; tbv[3] = 16'h0007; tc[3] = 0; ts[3] = 1; es[3] = 16'hFFFE; ec[3] = 0; eo[3] = 0;
      ta[4] = 16'h8000; tbv[4] = 16'h0001; tc[4] = 0; ts[4] = 1; es[4] = 16'h7FFF; ec[4] = 1; eo[4] = 1;
      ta[5] = 16'h0005; tbv[5] = 16'h0007; tc[5] = 1; ts[5] = 1; es[5] = 16'hFFFE; ec[5] = 0; eo[5] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      rst_rnd = 1'b0;
      rnd_go  = 1'b1;

      // Reset state
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_cout", 64'(cout), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));

      // Add/sub corner cases with latency check
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tbv[i], tc[i], ts[i]);
         wait_result($sformatf("dir%0d", i), es[i], ec[i], eo[i]);
         take($sformatf("dir%0d", i));
      end

      // Back-pressure in DONE with a competing request
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      wait_result("bp", 16'h3333, 1'b0, 1'b0);
      a        = 16'hAAAA;
      b        = 16'h1111;
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(out_valid), 64'(1));
         chk("bp_hold_rdy", 64'(in_ready), 64'(0));
         chk("bp_hold_sum", 64'(sum), 64'(16'h3333));
         chk("bp_hold_cout", 64'(cout), 64'(0));
         chk("bp_hold_ovf", 64'(ovf), 64'(0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_rdy", 64'(in_ready), 64'(1));
      chk("bp_idle_ovld", 64'(out_valid), 64'(0));
      @(negedge clk);
      in_valid = 1'b0;
      wait_result("bp_next", 16'hBBBB, 1'b0, 1'b0);
      take("bp_next");

      // Reset in the second RUN cycle drops the operation
      issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_rdy", 64'(in_ready), 64'(1));
      chk("mid_rst_ovld", 64'(out_valid), 64'(0));
      chk("mid_rst_sum", 64'(sum), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      ov_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      chk("mid_rst_no_pulse", 64'(ov_seen), 64'(0));
      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_result("post_rst", 16'h5555, 1'b0, 1'b0);
      take("post_rst");

      // Wait (bounded) for the randomized regressions
      t = 0;
      while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("rnd_complete", 64'(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
